// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Main control FSM of a multicycle MIPS datapath. Walks each
//                instruction through fetch, decode, execute, memory and
//                writeback, driving ALU op, mux selects and write enables.
//                Stalls on mem_ready and flags undecodable opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [1:0]         alu_op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               pc_en,
  output logic               illegal_op,
  output logic               retire,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADR  = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_EXECUTE = STATE_W'(6),
    S_ALUWB   = STATE_W'(7),
    S_BRANCH  = STATE_W'(8),
    S_ADDIEX  = STATE_W'(9),
    S_ADDIWB  = STATE_W'(10),
    S_JUMP    = STATE_W'(11)
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_pc_write;
  logic   w_branch;

  assign state = r_state;

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state and output decode from the registered state
  always_comb begin
    w_next     = S_FETCH;
    w_pc_write = 1'b0;
    w_branch   = 1'b0;
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    retire     = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        ir_write   = mem_ready;
        w_pc_write = mem_ready;
        w_next     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded
        alu_src_b = 2'b11;
        case (opcode)
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_RTYPE:       w_next = S_EXECUTE;
          c_OP_BEQ:         w_next = S_BRANCH;
          c_OP_ADDI:        w_next = S_ADDIEX;
          c_OP_J:           w_next = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            retire     = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == c_OP_LW)      w_next = S_MEMRD;
        else if (opcode == c_OP_SW) w_next = S_MEMWR;
        else                        w_next = S_FETCH;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        w_next   = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
        w_next    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        w_branch  = 1'b1;
        retire    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        w_pc_write = 1'b1;
        retire     = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase

    pc_en = w_pc_write | (w_branch & zero);

    // Reset overrides the decode so no enable can glitch while it is held
    if (reset) begin
      alu_op     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b01;
      pc_src     = 2'b00;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      pc_en      = 1'b0;
      illegal_op = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_fsm
//  Description : Self-checking bench for multicycle_control_fsm. A reference
//                model expands each instruction into its expected cycle
//                sequence and output set; every cycle is compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       pc_en;
  logic       illegal_op;
  logic       retire;
  logic [3:0] state;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [5:0] c_R    = 6'b000000;
  localparam logic [5:0] c_LW   = 6'b100011;
  localparam logic [5:0] c_SW   = 6'b101011;
  localparam logic [5:0] c_BEQ  = 6'b000100;
  localparam logic [5:0] c_ADDI = 6'b001000;
  localparam logic [5:0] c_J    = 6'b000010;

  // Output vector during reset: everything 0 except alu_src_b = 01
  localparam logic [20:0] c_RESET_VEC = {4'd0, 2'b00, 1'b0, 2'b01, 2'b00, 10'b0};

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_en(pc_en),
    .illegal_op(illegal_op), .retire(retire), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] observed();
    return {state, alu_op, alu_src_a, alu_src_b, pc_src, iord, mem_read, mem_write,
            ir_write, reg_dst, mem_to_reg, reg_write, pc_en, illegal_op, retire};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == c_R) || (op == c_LW) || (op == c_SW) || (op == c_BEQ) ||
           (op == c_ADDI) || (op == c_J);
  endfunction

  // Reference: expected outputs of one cycle given the phase the instruction is in
  function automatic logic [20:0] model(input int st, input logic rdy, input logic z,
                                        input logic ill);
    logic [1:0] aop, srcb, psrc;
    logic       srca, io, mr, mw, irw, rd, m2r, rw, pce, il, ret;
    aop = 0; srcb = 0; psrc = 0; srca = 0; io = 0; mr = 0; mw = 0; irw = 0;
    rd = 0; m2r = 0; rw = 0; pce = 0; il = 0; ret = 0;
    case (st)
      0:  begin mr = 1; srcb = 2'b01; irw = rdy; pce = rdy; end
      1:  begin srcb = 2'b11; il = ill; ret = ill; end
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; ret = 1; end
      5:  begin mw = 1; io = 1; ret = rdy; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; ret = 1; end
      8:  begin srca = 1; aop = 2'b01; psrc = 2'b01; pce = z; ret = 1; end
      9:  begin srca = 1; srcb = 2'b10; end
      10: begin rw = 1; ret = 1; end
      11: begin psrc = 2'b10; pce = 1; ret = 1; end
      default: ;
    endcase
    return {4'(st), aop, srca, srcb, psrc, io, mr, mw, irw, rd, m2r, rw, pce, il, ret};
  endfunction

  // One clock cycle: drive inputs after the falling edge, then compare
  task automatic cyc(input int st, input logic rdy, input logic z, input logic [5:0] op,
                     input logic ill, input string name);
    logic [20:0] exp_v, act_v;
    @(negedge clk);
    mem_ready = rdy;
    zero      = z;
    opcode    = op;
    #1;
    exp_v = model(st, rdy, z, ill);
    act_v = observed();
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL %s state%0d: got %h expected %h", name, st, act_v, exp_v);
    end
  endtask

  // Expand one instruction into its cycle sequence and check every cycle
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                           input logic bz, input string name);
    logic ill;
    ill = !is_legal(op);
    for (int i = 0; i < fstall; i++)
      cyc(0, 1'b0, 1'($urandom), 6'($urandom), 1'b0, name);
    cyc(0, 1'b1, 1'($urandom), 6'($urandom), 1'b0, name);
    cyc(1, 1'($urandom), 1'($urandom), op, ill, name);
    case (op)
      c_LW: begin
        cyc(2, 1'($urandom), 1'($urandom), op, 1'b0, name);
        for (int i = 0; i < mstall; i++) cyc(3, 1'b0, 1'($urandom), op, 1'b0, name);
        cyc(3, 1'b1, 1'($urandom), op, 1'b0, name);
        cyc(4, 1'($urandom), 1'($urandom), op, 1'b0, name);
      end
      c_SW: begin
        cyc(2, 1'($urandom), 1'($urandom), op, 1'b0, name);
        for (int i = 0; i < mstall; i++) cyc(5, 1'b0, 1'($urandom), op, 1'b0, name);
        cyc(5, 1'b1, 1'($urandom), op, 1'b0, name);
      end
      c_R: begin
        cyc(6, 1'($urandom), 1'($urandom), op, 1'b0, name);
        cyc(7, 1'($urandom), 1'($urandom), op, 1'b0, name);
      end
      c_BEQ:  cyc(8, 1'($urandom), bz, op, 1'b0, name);
      c_ADDI: begin
        cyc(9, 1'($urandom), 1'($urandom), op, 1'b0, name);
        cyc(10, 1'($urandom), 1'($urandom), op, 1'b0, name);
      end
      c_J:    cyc(11, 1'($urandom), 1'($urandom), op, 1'b0, name);
      default: ;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = c_R;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (observed() !== c_RESET_VEC) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected %h", observed(), c_RESET_VEC);
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_rtype();      run_instr(c_R, 0, 0, 1'b0, "rtype"); endtask
  task automatic test_lw_stall();   run_instr(c_LW, 0, 2, 1'b0, "lw_stall"); endtask
  task automatic test_sw_stall();   run_instr(c_SW, 0, 1, 1'b0, "sw_stall"); endtask
  task automatic test_addi_j();
    run_instr(c_ADDI, 1, 0, 1'b0, "addi");
    run_instr(c_J, 0, 0, 1'b0, "jump");
  endtask
  task automatic test_beq();
    run_instr(c_BEQ, 0, 0, 1'b1, "beq_taken");
    run_instr(c_BEQ, 0, 0, 1'b0, "beq_not_taken");
  endtask
  task automatic test_illegal();    run_instr(6'b111111, 0, 0, 1'b0, "illegal"); endtask

  task automatic test_async_reset();
    cyc(0, 1'b1, 1'b0, c_R, 1'b0, "async_rst");
    cyc(1, 1'b0, 1'b0, c_SW, 1'b0, "async_rst");
    cyc(2, 1'b0, 1'b0, c_SW, 1'b0, "async_rst");
    cyc(5, 1'b0, 1'b0, c_SW, 1'b0, "async_rst");
    // Assert reset between clock edges; outputs must clear before next edge
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (observed() !== c_RESET_VEC) begin
      tests_failed++;
      $display("FAIL async_rst_clear: got %h expected %h", observed(), c_RESET_VEC);
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    cyc(0, 1'b0, 1'b0, c_R, 1'b0, "post_rst_wait");
    cyc(0, 1'b0, 1'b1, c_R, 1'b0, "post_rst_wait");
    cyc(0, 1'b1, 1'b0, c_R, 1'b0, "post_rst_fetch");
    cyc(1, 1'b0, 1'b0, c_R, 1'b0, "post_rst_decode");
    cyc(6, 1'b0, 1'b0, c_R, 1'b0, "post_rst_exec");
    cyc(7, 1'b0, 1'b0, c_R, 1'b0, "post_rst_wb");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [7];
    logic [5:0] op;
    ops = '{c_R, c_LW, c_SW, c_BEQ, c_ADDI, c_J, 6'b000000};
    for (int n = 0; n < 150; n++) begin
      int k;
      k = int'($urandom_range(0, 6));
      op = ops[k];
      if (k == 6) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_stall();
    test_beq();
    test_addi_j();
    test_illegal();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Produces the 2-bit alu_op that is decoded by the ALU control unit, plus all datapath mux selects and write enables.
- Stalls on a memory ready handshake; flags illegal opcodes.

Parameters:
- STATE_W, 4, width of the state register and of the state debug port.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction register bits [31:26].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory handshake; access completes in the cycle it is high.
- alu_op  output  2  00 add, 01 sub, 10 R-type (funct decides).
- alu_src_a  output  1  0 PC, 1 register A.
- alu_src_b  output  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- iord  output  1  0 PC address, 1 ALUOut address.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  0 rt, 1 rd.
- mem_to_reg  output  1  0 ALUOut, 1 memory data register.
- reg_write  output  1  register file write.
- pc_en  output  1  PC load: (pc_write) OR (branch AND zero).
- illegal_op  output  1  one-cycle pulse on an undecodable opcode.
- retire  output  1  high in the final cycle of every instruction.
- state  output  STATE_W  current state, for debug.

Behaviour:
- Reset: asynchronous; state = FETCH (0). While reset is high, all enables are forced 0: mem_read, mem_write, ir_write, reg_write, pc_en, illegal_op and retire. All other outputs are 0 during reset, except alu_src_b = 01.
- Outputs decode from the registered state. Any signal not listed for a state is 0.
- Only mem_ready, zero and opcode gate enables and transitions within a state.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- FETCH (0):
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=mem_ready, pc_write=mem_ready.
  - Next: DECODE if mem_ready, else hold in FETCH.
- DECODE (1):
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - Next: lw/sw -> MEMADR, R -> EXECUTE, beq -> BRANCH, addi -> ADDIEX, j -> JUMP.
  - Any other opcode -> FETCH, with illegal_op=1 and retire=1 this cycle.
- MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD (3): mem_read=1, iord=1. Hold until mem_ready, then -> MEMWB.
- MEMWB (4): reg_write=1, reg_dst=0, mem_to_reg=1, retire=1. Next: FETCH.
- MEMWR (5): mem_write=1, iord=1. Hold with mem_write high until mem_ready; that cycle retire=1, then -> FETCH.
- EXECUTE (6): alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB (7): reg_write=1, reg_dst=1, mem_to_reg=0, retire=1. Next: FETCH.
- BRANCH (8):
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, so pc_en=zero; retire=1.
  - Next: FETCH.
- ADDIEX (9): alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
- ADDIWB (10): reg_write=1, reg_dst=0, mem_to_reg=0, retire=1. Next: FETCH.
- JUMP (11): pc_src=10, pc_write=1 (pc_en=1), retire=1. Next: FETCH.
- Unused encodings (12-15): next state FETCH, all enables 0.
- Latency with mem_ready tied high: lw 5 cycles, sw/R/addi 4, beq/j 3, illegal 2. Each stalled cycle adds 1.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- opcode is sampled only in DECODE and MEMADR; the instruction register holds it stable.
- Reset mid-instruction: immediate return to FETCH. No write enable may glitch high after reset asserts.

Test Plan:
- Reset, mem_ready=1, opcode=000000 -> states 0,1,6,7,0; alu_op=10 in state 6; reg_write=1, reg_dst=1 in state 7; retire high only in state 7.
- lw (100011), mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; mem_to_reg=1 and reg_write=1 in state 4.
- sw (101011), mem_ready low 1 cycle in MEMWR -> mem_write high 2 cycles, iord=1 throughout; no reg_write.
- beq (000100) with zero=1, then with zero=0 -> alu_op=01, pc_src=01 in state 8; pc_en=1 for zero=1, pc_en=0 for zero=0.
- opcode 111111 -> illegal_op and retire pulse for 1 cycle in DECODE, next state FETCH, no write enables.
- Assert reset asynchronously mid-MEMWR -> state=0 and mem_write=0 before the next clk edge. After release, FETCH waits on mem_ready.
